// File: rtl/data_mem_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_bus_if
// Description : Load/store handshake bundle between the CPU and data_mem_bus.
//               The master drives a request that it holds until ack; the
//               slave answers with a one-cycle ack and the read data.
// Ports       : req, we, addr, w_data  (master -> slave)
//               r_data, ack            (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_bus_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] w_data;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  ack;

   modport master (output req, we, addr, w_data, input  r_data, ack);
   modport slave  (input  req, we, addr, w_data, output r_data, ack);
endinterface
`default_nettype wire

// File: rtl/data_mem_bus.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_bus
// Description : Parametrised data memory with req/ack handshake, programmable
//               wait states and a memory-mapped I/O window.
//               Address map: 0..DEPTH-1 RAM, IO_BASE..IO_BASE+NUM_IO-1 I/O,
//               everything else reads 0 and drops writes (still acked).
// Ports       : clock    - system clock, rising edge
//               reset_n  - asynchronous active-low reset
//               bus      - data_mem_bus_if.slave (req/we/addr/w_data/r_data/ack)
//               io_in    - asynchronous input ports, channel k at [k*DW +: DW]
//               io_out   - registered output ports, same packing
//               err      - (DATA_MEM_BUS_ERR_EN) pulses with ack on unmapped access
//               err_addr - (DATA_MEM_BUS_ERR_EN) address of last unmapped access
// Options     : define DATA_MEM_BUS_ERR_EN to add err/err_addr reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_bus #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 8,
   parameter int DEPTH       = 192,
   parameter int IO_BASE     = 240,
   parameter int NUM_IO      = 4,
   parameter int WAIT_STATES = 1
) (
   input  logic                         clock,
   input  logic                         reset_n,
   data_mem_bus_if.slave                bus,
   input  logic [NUM_IO*DATA_WIDTH-1:0] io_in,
   output logic [NUM_IO*DATA_WIDTH-1:0] io_out
`ifdef DATA_MEM_BUS_ERR_EN
   ,
   output logic                         err,
   output logic [ADDR_WIDTH-1:0]        err_addr
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   localparam int                  c_wait_m1  = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
   localparam logic [3:0]          c_cnt_init = c_wait_m1[3:0];
   localparam int                  c_ram_aw   = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH:0] c_depth    = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] c_io_base  = IO_BASE[ADDR_WIDTH:0];

   state_t                  r_state, w_state_nxt;
   logic [3:0]              r_cnt, w_cnt_nxt;
   logic                    w_enter_ack;
   logic                    r_ack;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic                    r_we;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [NUM_IO*DATA_WIDTH-1:0] r_sync1, r_sync2;
   logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];

   logic                    w_acc_we;
   logic [ADDR_WIDTH-1:0]   w_acc_addr;
   logic [DATA_WIDTH-1:0]   w_acc_wdata;
   logic [ADDR_WIDTH:0]     w_addr_x;
   logic [c_ram_aw-1:0]     w_ram_idx;
   logic                    w_in_ram;
   logic [NUM_IO-1:0]       w_io_sel;
   logic                    w_in_io;
   logic [DATA_WIDTH-1:0]   w_io_rd;
   logic [DATA_WIDTH-1:0]   w_rd_val;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // w_enter_ack marks the edge on which the access is performed.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_enter_ack = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.req) begin
               if (WAIT_STATES == 0) begin
                  w_state_nxt = S_ACK;
                  w_enter_ack = 1'b1;
               end else begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = c_cnt_init;
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = S_ACK;
               w_enter_ack = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_ACK:   w_state_nxt = S_IDLE;   // req ignored: no double issue
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------ access select
   // With zero wait states the access completes on the sampling edge, so
   // the live bus values are used in IDLE and the latched copy afterwards.
   assign w_acc_we    = (r_state == S_IDLE) ? bus.we     : r_we;
   assign w_acc_addr  = (r_state == S_IDLE) ? bus.addr   : r_addr;
   assign w_acc_wdata = (r_state == S_IDLE) ? bus.w_data : r_wdata;

   assign w_addr_x  = {1'b0, w_acc_addr};
   assign w_ram_idx = w_acc_addr[c_ram_aw-1:0];
   assign w_in_ram  = (w_addr_x < c_depth);
   assign w_in_io   = |w_io_sel;

   always_comb begin
      w_io_sel = '0;
      w_io_rd  = '0;
      for (int k = 0; k < NUM_IO; k++) begin
         if (w_addr_x == (c_io_base + k[ADDR_WIDTH:0])) begin
            w_io_sel[k] = 1'b1;
            w_io_rd     = r_sync2[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      w_rd_val = '0;
      if (w_in_ram)
         w_rd_val = r_mem[w_ram_idx];
      else if (w_in_io)
         w_rd_val = w_io_rd;
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_ack   <= 1'b0;
         r_rdata <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_ack   <= w_enter_ack;
         r_sync1 <= io_in;
         r_sync2 <= r_sync1;
         if (r_state == S_IDLE && bus.req) begin
            r_we    <= bus.we;
            r_addr  <= bus.addr;
            r_wdata <= bus.w_data;
         end
         if (w_enter_ack && !w_acc_we)
            r_rdata <= w_rd_val;
      end
   end

   // RAM is not reset; reset_n gates the write so an access that would
   // complete while reset is asserted is discarded.
   always_ff @(posedge clock) begin
      if (reset_n && w_enter_ack && w_acc_we && w_in_ram)
         r_mem[w_ram_idx] <= w_acc_wdata;
   end

   for (genvar k = 0; k < NUM_IO; k++) begin : g_io_ch
      logic [DATA_WIDTH-1:0] r_ch;
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n)
            r_ch <= '0;
         else if (w_enter_ack && w_acc_we && w_io_sel[k])
            r_ch <= w_acc_wdata;
      end
      assign io_out[k*DATA_WIDTH +: DATA_WIDTH] = r_ch;
   end

   assign bus.ack    = r_ack;
   assign bus.r_data = r_rdata;

`ifdef DATA_MEM_BUS_ERR_EN
   logic                  w_unmapped;
   logic                  r_err;
   logic [ADDR_WIDTH-1:0] r_err_addr;

   assign w_unmapped = !w_in_ram && !w_in_io;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_err      <= 1'b0;
         r_err_addr <= '0;
      end else begin
         r_err <= w_enter_ack && w_unmapped;
         if (w_enter_ack && w_unmapped)
            r_err_addr <= w_acc_addr;
      end
   end

   assign err      = r_err;
   assign err_addr = r_err_addr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_bus.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_bus
// Description : Self-checking bench for data_mem_bus. A driver issues
//               accesses and queues the reference model's expected response;
//               a monitor pops and compares on every ack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_bus;
   localparam int DW      = 8;
   localparam int AW      = 8;
   localparam int DEPTH   = 192;
   localparam int IO_BASE = 240;
   localparam int NUM_IO  = 4;
   localparam int WS      = 1;

   typedef struct packed {
      logic [DW-1:0]        rd;
      logic [NUM_IO*DW-1:0] io;
      logic                 er;
      logic [AW-1:0]        ea;
   } exp_t;

   logic                 clock = 1'b0;
   logic                 reset_n = 1'b0;
   logic [NUM_IO*DW-1:0] io_in = '0;
   logic [NUM_IO*DW-1:0] io_out;

   data_mem_bus_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef DATA_MEM_BUS_ERR_EN
   logic          err;
   logic [AW-1:0] err_addr;
`endif

   data_mem_bus #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH),
      .IO_BASE    (IO_BASE),
      .NUM_IO     (NUM_IO),
      .WAIT_STATES(WS)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus),
      .io_in   (io_in),
      .io_out  (io_out)
`ifdef DATA_MEM_BUS_ERR_EN
      ,
      .err     (err),
      .err_addr(err_addr)
`endif
   );

   always #5 clock = ~clock;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t q[$];

   // Reference model state
   logic [DW-1:0]        m_mem [0:255];
   logic [NUM_IO*DW-1:0] m_io = '0;
   logic [DW-1:0]        m_rd = '0;
   logic [AW-1:0]        m_ea = '0;

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic exp_t model(bit w, int a, logic [DW-1:0] d);
      exp_t e;
      e.er = 1'b0;
      if (a < DEPTH) begin
         if (w) m_mem[a] = d; else m_rd = m_mem[a];
      end else if (a >= IO_BASE && a < IO_BASE + NUM_IO) begin
         if (w) m_io[(a-IO_BASE)*DW +: DW] = d;
         else   m_rd = io_in[(a-IO_BASE)*DW +: DW];
      end else begin
         if (!w) m_rd = '0;
         e.er = 1'b1;
         m_ea = a[AW-1:0];
      end
      e.rd = m_rd;
      e.io = m_io;
      e.ea = m_ea;
      return e;
   endfunction

   // Issue one access, scramble the bus while waiting, check latency.
   task automatic access(input bit w, input int a, input logic [DW-1:0] d);
      int cyc;
      bit seen;
      @(negedge clock);
      q.push_back(model(w, a, d));
      bus.req = 1'b1; bus.we = w; bus.addr = a[AW-1:0]; bus.w_data = d;
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clock);
         cyc++;
         if (bus.ack) seen = 1'b1;
         else begin
            bus.addr = AW'($urandom); bus.w_data = DW'($urandom); bus.we = 1'($urandom);
         end
      end
      bus.req = 1'b0;
      if (!seen) begin
         n_vec++; n_err++;
         $display("FAIL ack_timeout: no ack after %0d cycles, required %0d", cyc, WS + 1);
      end else
         check("latency", cyc, WS + 1);
   endtask

   task automatic set_io_in(input logic [NUM_IO*DW-1:0] v);
      @(negedge clock);
      io_in = v;
      repeat (3) @(negedge clock);
   endtask

   // Monitor
   initial begin
      bit   prev_ack;
      exp_t e;
      prev_ack = 1'b0;
      forever begin
         @(negedge clock);
         if (bus.ack) begin
            check("ack_width", {31'd0, prev_ack}, 32'd0);
            if (q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_ack: ack with empty queue, required none");
            end else begin
               e = q.pop_front();
               check("r_data", bus.r_data, e.rd);
               check("io_out", io_out, e.io);
`ifdef DATA_MEM_BUS_ERR_EN
               check("err", err, e.er);
               check("err_addr", err_addr, e.ea);
`endif
            end
         end
         prev_ack = bus.ack;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   // Driver
   initial begin
      int acks, cyc, last;
      bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.w_data = '0;
      repeat (3) @(negedge clock);
      check("rst_ack", bus.ack, 0);
      check("rst_rdata", bus.r_data, 0);
      check("rst_io_out", io_out, 0);
      reset_n = 1'b1;

      // Directed write then read-back
      access(1'b1, 8'h10, 8'hA5);
      access(1'b0, 8'h10, 8'h00);

      // Preload every RAM word
      for (int a = 0; a < DEPTH; a++) access(1'b1, a, DW'($urandom));
      access(1'b1, 3, 8'h3C);

      // Held req: three reads, acks one period apart
      @(negedge clock);
      repeat (3) q.push_back(model(1'b0, 3, 8'h00));
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = 8'd3;
      acks = 0; cyc = 0; last = -1;
      while (acks < 3 && cyc < 60) begin
         @(negedge clock);
         cyc++;
         if (bus.ack) begin
            acks++;
            if (last >= 0) check("b2b_period", cyc - last, WS + 2);
            else            check("b2b_first", cyc, WS + 1);
            last = cyc;
         end
      end
      bus.req = 1'b0;
      check("b2b_acks", acks, 3);

      // I/O window
      access(1'b1, 241, 8'h7E);
      set_io_in({8'h99, 8'h12, 8'h34, 8'h56});
      access(1'b0, 243, 8'h00);
      access(1'b0, 240, 8'h00);

      // Unmapped: hole and unused I/O slot
      access(1'b0, 200, 8'h00);
      access(1'b0, 250, 8'h00);
      access(1'b1, 200, 8'h55);
      access(1'b1, 250, 8'h66);

      // Random traffic
      for (int i = 0; i < 150; i++) begin
         int r, a;
         r = $urandom_range(0, 9);
         if      (r <= 5) a = $urandom_range(0, DEPTH - 1);
         else if (r <= 7) a = $urandom_range(IO_BASE, IO_BASE + NUM_IO - 1);
         else if (r == 8) a = $urandom_range(DEPTH, IO_BASE - 1);
         else             a = $urandom_range(IO_BASE + NUM_IO, 255);
         if ($urandom_range(0, 9) == 0) set_io_in($urandom);
         access(1'($urandom), a, DW'($urandom));
      end

      // Make sure io_out is nonzero, then reset in the middle of a write
      access(1'b1, 242, 8'hC3);
      access(1'b1, 5, 8'h00);
      access(1'b0, 16, 8'h00);
      @(negedge clock);
      bus.req = 1'b1; bus.we = 1'b1; bus.addr = 8'd5; bus.w_data = 8'h11;
      @(negedge clock);
      reset_n = 1'b0;
      repeat (3) begin
         @(negedge clock);
         check("rst_mid_ack", bus.ack, 0);
         check("rst_mid_io_out", io_out, 0);
         check("rst_mid_rdata", bus.r_data, 0);
      end
      bus.req = 1'b0;
      reset_n = 1'b1;
      m_io = '0; m_rd = '0; m_ea = '0;
      repeat (3) @(negedge clock);

      access(1'b0, 5, 8'h00);
      access(1'b0, 243, 8'h00);
      access(1'b1, 7, 8'h5A);
      access(1'b0, 7, 8'h00);

      repeat (5) @(negedge clock);
      check("queue_empty", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
